// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 receiver with deglitch filters, frame checker and first-word-fall-through byte FIFO
module ps2_rx_fifo #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    output logic [7:0]                  rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic                        parity_err,
    output logic                        frame_err,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FLM1 = FILTER_LEN - 1;

    localparam logic [7:0]    FL_LAST = FLM1[7:0];
    localparam logic [TW-1:0] TO_LAST = TIMEOUT_CYCLES[TW-1:0];
    localparam logic [CW-1:0] DEPTH   = FIFO_DEPTH[CW-1:0];

    typedef enum logic [1:0] {IDLE, SHIFT, STOP} state_t;

    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic          clk_f, data_f, clk_f_d;
    logic [7:0]    clk_cnt, data_cnt;
    logic          fall;
    state_t        state, state_nx;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] timer;
    logic          timeout, frame_done, parity_ok, stop_ok, push;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, pop, wr_en;

    // two-flop synchronisers for the asynchronous pins; the bus idles high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    // deglitch filters: a line flips only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_f    <= 1'b1;
            data_f   <= 1'b1;
            clk_f_d  <= 1'b1;
            clk_cnt  <= '0;
            data_cnt <= '0;
        end else begin
            clk_f_d <= clk_f;
            if (clk_s2 == clk_f) begin
                clk_cnt <= '0;
            end else if (clk_cnt == FL_LAST) begin
                clk_f   <= clk_s2;
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + 8'd1;
            end
            if (data_s2 == data_f) begin
                data_cnt <= '0;
            end else if (data_cnt == FL_LAST) begin
                data_f   <= data_s2;
                data_cnt <= '0;
            end else begin
                data_cnt <= data_cnt + 8'd1;
            end
        end
    end

    assign fall       = clk_f_d & ~clk_f;
    assign timeout    = (state != IDLE) && !fall && (timer == TO_LAST);
    assign frame_done = (state == STOP) && fall;
    assign parity_ok  = ^{shreg, par_bit};
    assign stop_ok    = data_f;
    assign push       = frame_done && parity_ok && stop_ok;

    // frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // frame next-state: start bit opens a frame, 8 data + parity bits, then the stop bit closes it
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (fall && !data_f) state_nx = SHIFT;
            SHIFT: begin
                if (timeout)                      state_nx = IDLE;
                else if (fall && bit_cnt == 4'd8) state_nx = STOP;
            end
            STOP:    if (fall || timeout) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // shift register, bit counter and inactivity timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            timer   <= '0;
        end else begin
            if (state == IDLE || fall)  timer <= '0;
            else if (timer != TO_LAST)  timer <= timer + TW'(1);
            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (state == SHIFT && fall) begin
                if (bit_cnt[3]) par_bit <= data_f;
                else            shreg   <= {data_f, shreg[7:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    // status pulses, registered so they appear one cycle after the deciding edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            parity_err <= frame_done && !parity_ok;
            frame_err  <= (frame_done && !stop_ok) || timeout;
            overflow   <= push && full && !pop;
        end
    end

    assign rx_valid = (fifo_count != '0);
    assign full     = (fifo_count == DEPTH);
    assign pop      = rx_valid && rx_ready;
    assign wr_en    = push && (!full || pop);
    assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

    // storage array; stale contents are never visible because rx_data is gated by rx_valid
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= shreg;
    end

    // pointers and occupancy; a push into a full FIFO lands in the slot freed by a same-cycle pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - randomized self-checking bench for ps2_rx_fifo with a queue-based model
module tb_ps2_rx_fifo;
    localparam int FL    = 4;
    localparam int TO    = 300;
    localparam int DEPTH = 4;
    localparam int HP    = 20;

    logic                     clk      = 1'b0;
    logic                     rst_n    = 1'b0;
    logic                     ps2_clk  = 1'b1;
    logic                     ps2_data = 1'b1;
    logic                     rx_ready = 1'b0;
    logic [7:0]               rx_data;
    logic                     rx_valid, parity_err, frame_err, overflow;
    logic [$clog2(DEPTH):0]   fifo_count;

    ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_cmp = 0, n_fail = 0;
    logic [7:0] exp_q[$];
    int         mode = 0;
    int         pend_cyc = -100;
    logic [7:0] pend_byte = 8'h00;
    bit         pend_pbad = 1'b0, pend_sbad = 1'b0;
    bit         in_rst = 1'b1, allow_to = 1'b0;
    int         to_seen = 0, ov_seen = 0, pe_seen = 0;
    logic [7:0] last_pop = 8'h00;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit pbad, input bit sbad);
        return {~sbad, (~^b) ^ pbad, b, 1'b0};
    endfunction

    // Send nbits of a frame, LSB (start bit) first; optional short low glitch before bit glitch_at.
    task automatic send(input logic [7:0] b, input bit pbad, input bit sbad, input int nbits, input int glitch_at);
        logic [10:0] f;
        f = frame_bits(b, pbad, sbad);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            if (i == glitch_at) begin
                repeat (2) @(negedge clk);
                ps2_clk = 1'b0;
                repeat (FL - 1) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (HP / 2 - 2 - (FL - 1)) @(negedge clk);
            end else begin
                repeat (HP / 2) @(negedge clk);
            end
            ps2_clk = 1'b0;
            if (i == 10) begin
                pend_byte = b;
                pend_pbad = pbad;
                pend_sbad = sbad;
                pend_cyc  = cyc + 3 + FL;
            end
            repeat (HP) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HP / 2) @(negedge clk);
        end
        ps2_data = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    // Model update and per-cycle compare of every output, then the consumer's ready decision.
    initial begin : compare
        logic e_pe, e_fe, e_ov;
        forever begin
            @(negedge clk);
            if (in_rst) continue;
            e_pe = 1'b0;
            e_fe = 1'b0;
            e_ov = 1'b0;
            if (cyc == pend_cyc) begin
                e_pe = pend_pbad;
                e_fe = pend_sbad;
                if (!pend_pbad && !pend_sbad) begin
                    if (exp_q.size() < DEPTH) exp_q.push_back(pend_byte);
                    else                      e_ov = 1'b1;
                end
            end
            if (overflow)   ov_seen++;
            if (parity_err) pe_seen++;
            chk("parity_err", parity_err, e_pe);
            chk("overflow", overflow, e_ov);
            if (allow_to) begin
                if (frame_err) to_seen++;
            end else begin
                chk("frame_err", frame_err, e_fe);
            end
            chk("rx_valid", rx_valid, exp_q.size() != 0);
            chk("fifo_count", fifo_count, exp_q.size());
            if (exp_q.size() != 0) chk("rx_data", rx_data, exp_q[0]);
            case (mode)
                0:       rx_ready = 1'b0;
                1:       rx_ready = 1'($urandom_range(0, 1));
                2:       rx_ready = 1'b1;
                default: rx_ready = (cyc == pend_cyc - 1);
            endcase
            if (rx_ready && exp_q.size() != 0) last_pop = exp_q.pop_front();
        end
    end

    initial begin : main
        logic [7:0] rb;
        bit         pb, sb;
        int         base;
        mode = 2;
        repeat (3) @(negedge clk);
        chk("reset rx_valid", rx_valid, 0);
        chk("reset fifo_count", fifo_count, 0);
        chk("reset rx_data", rx_data, 0);
        chk("reset errs", {parity_err, frame_err, overflow}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        in_rst = 1'b0;

        chk("frame_bits 1C", frame_bits(8'h1C, 1'b0, 1'b0), 11'h438);
        chk("frame_bits F0", frame_bits(8'hF0, 1'b0, 1'b0), 11'h7E0);

        send(8'h1C, 1'b0, 1'b0, 11, -1);
        chk("t1 byte", last_pop, 8'h1C);
        chk("t1 count", fifo_count, 0);

        base = pe_seen;
        send(8'h1C, 1'b1, 1'b0, 11, -1);
        chk("t2 parity pulses", pe_seen - base, 1);
        send(8'hF0, 1'b0, 1'b0, 11, -1);
        chk("t2 byte", last_pop, 8'hF0);

        allow_to = 1'b1;
        to_seen  = 0;
        send(8'h00, 1'b0, 1'b0, 5, -1);
        repeat (TO + 40) @(negedge clk);
        allow_to = 1'b0;
        chk("t3 timeout pulses", to_seen, 1);
        send(8'h5A, 1'b0, 1'b0, 11, -1);
        chk("t3 byte", last_pop, 8'h5A);

        mode = 0;
        base = ov_seen;
        for (int i = 0; i < DEPTH + 1; i++) send(8'h30 + 8'(i), 1'b0, 1'b0, 11, -1);
        chk("t4 full count", fifo_count, 4);
        chk("t4 overflow pulses", ov_seen - base, 1);
        mode = 2;
        repeat (10) @(negedge clk);
        chk("t4 last drained", last_pop, 8'h33);
        chk("t4 empty", fifo_count, 0);

        send(8'hA5, 1'b0, 1'b0, 11, 4);
        chk("t5 glitch byte", last_pop, 8'hA5);

        mode = 0;
        send(8'h11, 1'b0, 1'b0, 11, -1);
        send(8'h22, 1'b0, 1'b0, 11, -1);
        send(8'h99, 1'b0, 1'b0, 6, -1);
        in_rst = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        pend_cyc = -100;
        repeat (3) @(negedge clk);
        chk("t5 reset rx_valid", rx_valid, 0);
        chk("t5 reset count", fifo_count, 0);
        chk("t5 reset errs", {parity_err, frame_err, overflow}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        in_rst = 1'b0;
        mode = 2;
        send(8'h3C, 1'b0, 1'b0, 11, -1);
        chk("t5 post-reset byte", last_pop, 8'h3C);

        mode = 0;
        for (int i = 0; i < DEPTH; i++) send(8'h40 + 8'(i), 1'b0, 1'b0, 11, -1);
        base = ov_seen;
        mode = 3;
        send(8'h77, 1'b0, 1'b0, 11, -1);
        chk("t6 count", fifo_count, 4);
        chk("t6 no overflow", ov_seen - base, 0);
        chk("t6 popped head", last_pop, 8'h40);
        mode = 2;
        repeat (10) @(negedge clk);
        chk("t6 last byte", last_pop, 8'h77);

        mode = 1;
        for (int i = 0; i < 12; i++) begin
            rb = 8'($urandom);
            pb = ($urandom_range(0, 4) == 0);
            sb = ($urandom_range(0, 5) == 0);
            send(rb, pb, sb, 11, -1);
        end
        mode = 2;
        repeat (10) @(negedge clk);
        chk("rand drained", fifo_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Clock-domain-synchronous PS/2 keyboard receiver. It oversamples the raw `ps2_clk`/`ps2_data` lines on the system clock, deglitches them, and decodes 11-bit frames (start, 8 data LSB-first, odd parity, stop). Decoded bytes are checked and then buffered in a first-word-fall-through FIFO with a valid/ready output handshake. It replaces the PS/2-clocked shift register between the keyboard pins and the scan-code consumer logic.

## Interface
- `FILTER_LEN`, default 8: consecutive identical synchronised samples required before a filtered line changes level (1..255).
- `TIMEOUT_CYCLES`, default 50000: system-clock cycles allowed without a filtered falling edge before a partial frame is abandoned.
- `FIFO_DEPTH`, default 16: byte entries; must be a power of two, at least 2.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous.
- `rx_data` out 8: FIFO head byte; valid only while `rx_valid`=1.
- `rx_valid` out 1: FIFO not empty.
- `rx_ready` in 1: consumer accepts head when `rx_valid`&`rx_ready` at a `clk` edge.
- `parity_err` out 1: one-cycle pulse, received frame failed odd parity.
- `frame_err` out 1: one-cycle pulse, bad stop bit or timeout.
- `overflow` out 1: one-cycle pulse, good byte dropped because FIFO full.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current occupancy.

## Operation
- Input path, per line: 2-flop synchroniser, then filter counter. Filtered level flips only after `FILTER_LEN` consecutive synchronised samples differing from it. Filtered levels reset to 1 (idle bus).
- `fall` strobe: one cycle, asserted in the same cycle filtered `ps2_clk` goes 1→0. Filtered `ps2_data` is sampled only on `fall`.
- FSM states: IDLE, SHIFT, STOP.
  - IDLE: on `fall` with data=0 → SHIFT, bit counter=0. On `fall` with data=1 → stay in IDLE, no error.
  - SHIFT: on each `fall`, shift in LSB-first (8 data bits, then parity into a separate flop), counter+1. After the 9th bit → STOP.
  - STOP: on `fall`, sample the stop bit and evaluate the frame, then → IDLE.
- Frame evaluation:
  - Parity OK when XOR(data, parity)=1.
  - Stop OK when the stop bit is 1.
  - Both OK: push the byte. If the FIFO is full and no pop occurs this cycle, drop the byte and pulse `overflow`.
  - Parity bad: pulse `parity_err`, no push.
  - Stop bad: pulse `frame_err`, no push.
  - Both bad: both pulses in the same cycle.
- Timeout: the idle counter clears on every `fall` and while in IDLE. In SHIFT or STOP, when it reaches `TIMEOUT_CYCLES`: → IDLE, pulse `frame_err`, discard partial data.
- FIFO: circular buffer with write/read pointers.
  - Pop when `rx_valid`&`rx_ready`.
  - Push and pop in the same cycle are both honoured, including when full (no overflow) and when empty-with-push (pop not possible since `rx_valid`=0).
  - `rx_data` is stable while `rx_valid`=1 and no pop occurs.
- Reset (any time, including mid-frame or mid-handshake):
  - State to IDLE; counters and FIFO cleared.
  - `rx_valid`, `parity_err`, `frame_err`, `overflow` = 0; `fifo_count` = 0; `rx_data` = 0.
  - The partial frame is discarded with no error pulse.

## Timing
- Raw `ps2_clk` fall, stable thereafter: synchronised level changes after 2 `clk` edges, and `fall` asserts FILTER_LEN edges later. Total latency is 2+FILTER_LEN cycles.
- Pulses shorter than FILTER_LEN cycles never produce `fall`.
- `ps2_data` has the same path delay as `ps2_clk`, so sampling happens the same number of cycles after its own transitions. PS/2 data is stable for ≥5 µs around the clock fall, which is sufficient while (2+FILTER_LEN)·Tclk < 5 µs.
- Push occurs on the stop-bit `fall` cycle; `rx_valid`/`fifo_count` update on the next cycle (1-cycle latency).
- Error and overflow pulses assert on the cycle after the stop-bit `fall` cycle (registered), for exactly 1 cycle.
- Pop: the new head or `rx_valid`=0 is visible on the cycle after the accepting edge.
- Throughput: 1 byte per frame. The consumer may hold `rx_ready` low indefinitely; the FIFO absorbs FIFO_DEPTH frames.

## Test plan
- Frame 0x1C (data bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12 kHz PS/2 clock, `rx_ready`=1 → `rx_valid` pulses with `rx_data`=0x1C, no error pulses, `fifo_count` returns to 0.
- Frame 0x1C with parity bit 1 → one `parity_err` pulse, `rx_valid` stays 0. Next frame 0xF0 with good parity is received correctly.
- 4-bit partial frame, then silence > TIMEOUT_CYCLES → one `frame_err` pulse, FSM in IDLE. Following frame 0x5A decodes as 0x5A.
- `rx_ready`=0, send FIFO_DEPTH+1 good frames → `fifo_count`=FIFO_DEPTH, one `overflow` pulse. Drain: bytes emerge in order, last dropped.
- `ps2_clk` glitches low for FILTER_LEN-1 cycles mid-frame → no bit shifted, frame decodes correctly. Also: `rst_n` low after bit 5 → no errors, `rx_valid`=0, next frame decodes.
- Full FIFO with `rx_ready`=1 on the stop-bit push cycle → no `overflow`, `fifo_count` unchanged, new byte appears last.
